// File: rtl/uart_bus_ctrl_if.sv
// Request, UART handshake and shared RAM1 data-bus signals of the UART access sequencer.
// slave is the sequencer; master is the pipeline/memory/UART side around it.
interface uart_bus_ctrl_if;
  logic        req_read;
  logic        req_write;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] bus_din;
  logic [15:0] bus_dout;
  logic        bus_oe;
  logic        rdn;
  logic        wrn;
  logic        tbre;
  logic        tsre;
  logic        data_ready;

  modport slave (
    input  req_read, req_write, addr, wdata, bus_din, tbre, tsre, data_ready,
    output rdata, busy, done, err, bus_dout, bus_oe, rdn, wrn
  );

  modport master (
    output req_read, req_write, addr, wdata, bus_din, tbre, tsre, data_ready,
    input  rdata, busy, done, err, bus_dout, bus_oe, rdn, wrn
  );
endinterface

// File: rtl/uart_bus_ctrl.sv
// UART access sequencer: turns MEM-stage loads/stores at the UART addresses into rdn/wrn strobe
// sequences on the shared RAM1 bus. Define UART_RX_BLOCK_EN to make data reads wait for data_ready.
module uart_bus_ctrl #(
  parameter logic [15:0] DATA_ADDR       = 16'hBF00,
  parameter logic [15:0] STAT_ADDR       = 16'hBF01,
  parameter int unsigned WR_PULSE_CYCLES = 2,
  parameter int unsigned RD_PULSE_CYCLES = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1023
) (
  input  logic            clk,
  input  logic            rst,
  uart_bus_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_LOW,
    S_WR_HOLD,
    S_WR_TBRE,
    S_WR_TSRE,
    S_RD_LOW,
    S_RD_REL,
    S_DONE
`ifdef UART_RX_BLOCK_EN
    , S_RX_WAIT
`endif
  } state_e;

  localparam logic [9:0] WR_LAST  = 10'(WR_PULSE_CYCLES - 1);
  localparam logic [9:0] RD_LAST  = 10'(RD_PULSE_CYCLES - 1);
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        accept_multi;

  logic is_data, is_stat;
  logic wr_data_req, rd_data_req, rd_stat_req;
  logic tmo;
  logic unused_hi;

  // A simultaneous read and write resolves to the write.
  assign is_data     = (bus.addr == DATA_ADDR);
  assign is_stat     = (bus.addr == STAT_ADDR);
  assign wr_data_req = bus.req_write & is_data;
  assign rd_data_req = bus.req_read & ~bus.req_write & is_data;
  assign rd_stat_req = bus.req_read & ~bus.req_write & is_stat;
  assign tmo         = (cnt_q == TMO_LAST);
  assign unused_hi   = ^{bus.wdata[15:8], bus.bus_din[15:8]};

  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    rdata_d      = rdata_q;
    err_d        = 1'b0;
    accept_multi = 1'b0;
    cnt_d        = 10'd0;

    case (state_q)
      S_IDLE: begin
        if (wr_data_req) begin
          accept_multi = 1'b1;
          byte_d       = bus.wdata[7:0];
          state_d      = S_WR_LOW;
        end else if (rd_data_req) begin
`ifdef UART_RX_BLOCK_EN
          accept_multi = 1'b1;
          state_d      = bus.data_ready ? S_RD_LOW : S_RX_WAIT;
`else
          if (bus.data_ready) begin
            accept_multi = 1'b1;
            state_d      = S_RD_LOW;
          end else begin
            rdata_d = 16'h0000;
            state_d = S_DONE;
          end
`endif
        end else if (rd_stat_req) begin
          rdata_d = {14'b0, bus.data_ready, bus.tbre & bus.tsre};
          state_d = S_DONE;
        end
      end
      S_WR_LOW: begin
        if (cnt_q == WR_LAST) state_d = S_WR_HOLD;
      end
      S_WR_HOLD: state_d = S_WR_TBRE;
      S_WR_TBRE: begin
        if (bus.tbre && bus.tsre) begin
          state_d = S_DONE;
        end else if (bus.tbre) begin
          state_d = S_WR_TSRE;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WR_TSRE: begin
        if (bus.tsre) begin
          state_d = S_DONE;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
`ifdef UART_RX_BLOCK_EN
      S_RX_WAIT: begin
        if (bus.data_ready) begin
          state_d = S_RD_LOW;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      S_RD_LOW: begin
        if (cnt_q == RD_LAST) begin
          byte_d  = bus.bus_din[7:0];
          state_d = S_RD_REL;
        end
      end
      S_RD_REL: begin
        rdata_d = {8'h00, byte_q};
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // One counter serves both pulse widths and wait timeouts; it restarts on every state change.
    if (state_d == state_q && state_q != S_IDLE && state_q != S_DONE) begin
      cnt_d = cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 10'd0;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Byte buffer only feeds gated outputs, so it carries no reset.
  always_ff @(posedge clk) begin
    byte_q <= byte_d;
  end

  always_comb begin
    bus.rdn      = (state_q != S_RD_LOW);
    bus.wrn      = (state_q != S_WR_LOW);
    bus.bus_oe   = (state_q == S_WR_LOW) || (state_q == S_WR_HOLD);
    bus.bus_dout = bus.bus_oe ? {8'h00, byte_q} : 16'h0000;
    bus.busy     = (state_q != S_IDLE && state_q != S_DONE) || accept_multi;
    bus.done     = (state_q == S_DONE);
    bus.err      = err_q;
    bus.rdata    = rdata_q;
  end

endmodule

// File: doc/uart_bus_ctrl.md
Name: uart_bus_ctrl

Overview:
- Serial-port access sequencer sitting directly downstream of the pipeline's MEM stage, beside the data-memory path.
- Turns single-cycle MEM-stage loads/stores to the UART data/status addresses into multi-cycle rdn/wrn strobe sequences on the shared RAM1 data bus, honouring the tbre/tsre/data_ready handshakes.
- Raises busy so the pipeline stalls until the access completes.
- Drives no tri-state itself: it exports bus_dout and bus_oe, and the memory module muxes these onto ram1_data.

Parameters:
- DATA_ADDR, 16'hBF00, UART data register address.
- STAT_ADDR, 16'hBF01, UART status register address.
- WR_PULSE_CYCLES, 2, cycles wrn is held low (1..15).
- RD_PULSE_CYCLES, 2, cycles rdn is held low (1..15).
- TIMEOUT_CYCLES, 1023, maximum cycles spent in any handshake wait state before aborting.

Ports:
- clk  in  1  system clock; the single clock, same as the pipeline core clock.
- rst  in  1  synchronous, active-high reset.
- req_read  in  1  MEM-stage load request.
- req_write  in  1  MEM-stage store request.
- addr  in  16  access address.
- wdata  in  16  store data; bits [7:0] are transmitted.
- rdata  out  16  load result, valid in the done cycle and held until the next done.
- busy  out  1  stall request to the hazard/PC logic.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout pulse.
- bus_din  in  16  ram1_data as read back.
- bus_dout  out  16  value to drive onto ram1_data.
- bus_oe  out  1  bus_dout drive enable.
- rdn  out  1  UART read strobe, active low.
- wrn  out  1  UART write strobe, active low.
- tbre  in  1  transmit buffer empty.
- tsre  in  1  transmit shift register empty.
- data_ready  in  1  receive byte available.

Behaviour:
- Reset values: rdn=1, wrn=1, bus_oe=0, bus_dout=0, rdata=0, busy=0, done=0, err=0, state=IDLE, timeout counter=0.
- Reset is synchronous and overrides all states, including mid-strobe; a strobe cut short by reset is not completed.
- Requests are sampled only in IDLE. The requestor holds the request stable until done.
- If req_read and req_write are both high, the write is taken.
- Addresses other than DATA_ADDR/STAT_ADDR are ignored: no busy, no done.
- busy = (state!=IDLE) OR (in IDLE, an accepted multi-cycle request present), combinational. It falls in the cycle done is high.
- Status read (req_read, addr=STAT_ADDR):
  - Never busy.
  - done=1 on the next edge, with rdata={14'b0, data_ready, tbre&tsre}.
  - Inputs are sampled at the request cycle.
- Data write (req_write, addr=DATA_ADDR). IDLE latches wdata[7:0]. States:
  - WR_LOW: bus_oe=1, bus_dout={8'h00, byte}, wrn=0 for WR_PULSE_CYCLES.
  - WR_HOLD: wrn=1, bus_oe=1 for 1 cycle.
  - WR_TBRE: bus_oe=0; wait for tbre=1.
  - WR_TSRE: wait for tsre=1.
  - DONE: done=1, return to IDLE.
  - Minimum latency with tbre/tsre already high: WR_PULSE_CYCLES+3 cycles from request to done.
- Data read (req_read, addr=DATA_ADDR). States:
  - RX_WAIT: only when UART_RX_BLOCK_EN is defined (see Optional Feature).
  - RD_LOW: rdn=0 for RD_PULSE_CYCLES; bus_din[7:0] is latched on the last low cycle.
  - RD_REL: rdn=1.
  - DONE: rdata={8'h00, byte}, done=1.
  - Minimum latency: RD_PULSE_CYCLES+2 cycles.
- Timeout:
  - A 10-bit counter clears on entry to each wait state and increments each cycle spent in it.
  - Reaching TIMEOUT_CYCLES triggers an abort: err=1 and done=1 in the same cycle, rdata unchanged, return to IDLE, strobes high, bus_oe=0.
- Never both rdn=0 and wrn=0.
- bus_oe=0 whenever rdn=0.

Optional Feature:
- UART_RX_BLOCK_EN defined:
  - A data read with data_ready=0 enters RX_WAIT (busy held, timeout counter active) until data_ready=1, then proceeds to RD_LOW.
- Not defined:
  - A data read with data_ready=0 completes on the next edge with rdata=16'h0000 and done=1, without strobing rdn.
  - RX_WAIT does not exist.

Test Plan:
- Reset then idle: hold rst 2 cycles → rdn=wrn=1, bus_oe=0, busy=done=err=0, rdata=0.
- Write 0x1234 to BF00, tbre=tsre=1 → wrn low exactly 2 cycles with bus_dout=0x0034, bus_oe=1; done on cycle 5 after request; busy high cycles 0-4.
- Write with tbre held low 20 cycles, then tsre low 5 more → busy held throughout; done 1 cycle after tsre rises; err=0.
- Read BF00 with data_ready=1, bus_din=0xAB5A → rdn low 2 cycles; done with rdata=0x005A; then read BF01 with data_ready=0, tbre=tsre=1 → rdata=0x0001, busy never asserted.
- Read BF00 with data_ready=0 → with UART_RX_BLOCK_EN: busy until data_ready rises at cycle 30, then rdata=byte; without: done next cycle, rdata=0x0000, rdn stays 1.
- Timeout: write with tbre stuck 0 → err=done=1 exactly 1023 cycles after WR_TBRE entry. Separately, assert rst during WR_LOW → wrn=1 and bus_oe=0 after that edge, no done.
